// File: rtl/mmu_pkg.sv
// Shared types and helpers for the N x N output-stationary systolic multiplier.
package mmu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FEED  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_OUT   = 2'd3
   } state_t;

   // Widest accumulator the output conversion helper accepts.
   localparam int unsigned SAT_W = 64;

   // The last skewed beat reaches PE(N-1,N-1) 2N-1 cycles after it is accepted.
   function automatic int unsigned drain_cycles(input int unsigned n);
      return 2 * n - 1;
   endfunction

   // Clamp to the largest data_w-bit value, or keep only the low data_w bits.
   function automatic logic [SAT_W-1:0] sat_trunc(input logic [SAT_W-1:0] acc,
                                                  input int unsigned      data_w,
                                                  input logic             sat_en);
      logic [SAT_W-1:0] max_v;
      logic [SAT_W-1:0] res;
      max_v = (SAT_W'(1) << data_w) - SAT_W'(1);
      if (sat_en) res = (acc > max_v) ? max_v : acc;
      else        res = acc & max_v;
      return res;
   endfunction

endpackage

// File: rtl/mmu_pe.sv
// One processing element: multiply-accumulate, forwarding a east and b south.
module mmu_pe
   import mmu_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ACC_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              clr,
   input  logic [DATA_W-1:0] a_in,
   input  logic [DATA_W-1:0] b_in,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] b_out,
   output logic [ACC_W-1:0]  acc
);

   localparam int unsigned PROD_W = 2 * DATA_W;

   logic [PROD_W-1:0] prod;

   assign prod = PROD_W'(a_in) * PROD_W'(b_in);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_out <= '0;
         b_out <= '0;
         acc   <= '0;
      end else begin
         if (en) begin
            a_out <= a_in;
            b_out <= b_in;
         end
         // A job-start clear wins over any MAC in the same cycle.
         if (clr)     acc <= '0;
         else if (en) acc <= acc + ACC_W'(prod);
      end
   end

endmodule

// File: rtl/mmu_array.sv
// N x N systolic matrix multiplier: streams K beats, skews, drains, then returns C row by row.
module mmu_array
   import mmu_pkg::*;
#(
   parameter int unsigned N      = 2,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ACC_W  = 16,
   parameter int unsigned K_W    = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [K_W-1:0]         k_len,
   input  logic                   acc_en,
   input  logic                   sat_en,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N*DATA_W-1:0]    in_a,
   input  logic [N*DATA_W-1:0]    in_b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [N*DATA_W-1:0]    out_row,
   output logic [$clog2(N)-1:0]   out_idx,
   output logic                   out_last,
   output logic                   busy,
   output logic                   done
);

   localparam int unsigned IDX_W     = $clog2(N);
   localparam int unsigned ROW_W     = N * DATA_W;
   localparam int unsigned DRAIN_CYC = drain_cycles(N);
   localparam int unsigned DCNT_W    = $clog2(DRAIN_CYC + 1);

   state_t             state_q, state_d;
   logic [K_W-1:0]     k_q, beat_q;
   logic               sat_q;
   logic [DCNT_W-1:0]  drain_q;
   logic               accept, out_hs, clr, adv, last_beat, sat_cur;
   logic [IDX_W-1:0]   row_d;
   logic [ROW_W-1:0]   row_data, out_row_d;
   logic               in_ready_d, out_valid_d, out_last_d, busy_d, done_d;
   logic [ROW_W-1:0]   a_in_q, b_in_q;

   logic [ACC_W-1:0]   acc_w [N][N];
   logic [DATA_W-1:0]  a_i [N][N];
   logic [DATA_W-1:0]  b_i [N][N];
   logic [DATA_W-1:0]  a_o [N][N];
   logic [DATA_W-1:0]  b_o [N][N];
   logic [DATA_W-1:0]  unused_east [N];
   logic [DATA_W-1:0]  unused_south [N];

   assign accept    = in_valid & in_ready;
   assign out_hs    = out_valid & out_ready;
   assign clr       = (state_q == ST_IDLE) & start & ~acc_en;
   assign adv       = (state_q == ST_FEED) | (state_q == ST_DRAIN);
   assign last_beat = accept & (beat_q == k_q - K_W'(1));
   // On the k_len=0 path the latched mode is not yet visible, so use the live input.
   assign sat_cur   = (state_q == ST_IDLE) ? sat_en : sat_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = (k_len == '0) ? ST_OUT : ST_FEED;
         ST_FEED:  if (last_beat) state_d = ST_DRAIN;
         ST_DRAIN: if (drain_q == DCNT_W'(DRAIN_CYC - 1)) state_d = ST_OUT;
         ST_OUT:   if (out_hs && (out_idx == IDX_W'(N - 1))) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready_d  = (state_d == ST_FEED);
      out_valid_d = (state_d == ST_OUT);
      busy_d      = (state_d != ST_IDLE);
      done_d      = (state_q == ST_OUT) && (state_d == ST_IDLE);
      row_d       = out_idx;
      if (state_d != ST_OUT)      row_d = '0;
      else if (state_q != ST_OUT) row_d = '0;
      else if (out_hs)            row_d = out_idx + IDX_W'(1);
      out_last_d  = (state_d == ST_OUT) && (row_d == IDX_W'(N - 1));
      row_data    = '0;
      for (int j = 0; j < N; j++)
         row_data[j*DATA_W +: DATA_W] =
            DATA_W'(sat_trunc(SAT_W'(acc_w[row_d][j]), DATA_W, sat_cur));
      // Row 0 is final one cycle before the drain ends, so it can be captured on entry.
      out_row_d   = out_row;
      if ((state_d == ST_OUT) && ((state_q != ST_OUT) || out_hs))
         out_row_d = clr ? '0 : row_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_row   <= '0;
         out_idx   <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         k_q       <= '0;
         sat_q     <= 1'b0;
         beat_q    <= '0;
         drain_q   <= '0;
         a_in_q    <= '0;
         b_in_q    <= '0;
      end else begin
         in_ready  <= in_ready_d;
         out_valid <= out_valid_d;
         out_row   <= out_row_d;
         out_idx   <= row_d;
         out_last  <= out_last_d;
         busy      <= busy_d;
         done      <= done_d;
         if ((state_q == ST_IDLE) && start) begin
            k_q   <= k_len;
            sat_q <= sat_en;
         end
         beat_q  <= (state_q == ST_FEED)  ? beat_q + K_W'(accept) : '0;
         drain_q <= (state_q == ST_DRAIN) ? drain_q + DCNT_W'(1)   : '0;
         // Bubbles and drain cycles inject zeros so they add nothing.
         if (adv) begin
            a_in_q <= accept ? in_a : '0;
            b_in_q <= accept ? in_b : '0;
         end
      end
   end

   // Row i of A and column j of B are delayed by their index before entering the array.
   for (genvar gi = 0; gi < N; gi++) begin : g_skew
      if (gi == 0) begin : g_direct
         assign a_i[gi][0] = a_in_q[gi*DATA_W +: DATA_W];
         assign b_i[0][gi] = b_in_q[gi*DATA_W +: DATA_W];
      end else begin : g_dly
         logic [DATA_W-1:0] a_dly [gi];
         logic [DATA_W-1:0] b_dly [gi];
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int k = 0; k < gi; k++) begin
                  a_dly[k] <= '0;
                  b_dly[k] <= '0;
               end
            end else if (adv) begin
               a_dly[0] <= a_in_q[gi*DATA_W +: DATA_W];
               b_dly[0] <= b_in_q[gi*DATA_W +: DATA_W];
               for (int k = 1; k < gi; k++) begin
                  a_dly[k] <= a_dly[k-1];
                  b_dly[k] <= b_dly[k-1];
               end
            end
         end
         assign a_i[gi][0] = a_dly[gi-1];
         assign b_i[0][gi] = b_dly[gi-1];
      end
      assign unused_east[gi]  = a_o[gi][N-1];
      assign unused_south[gi] = b_o[N-1][gi];
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_row
      for (genvar gj = 0; gj < N; gj++) begin : g_col
         if (gj > 0) begin : g_a_fwd
            assign a_i[gi][gj] = a_o[gi][gj-1];
         end
         if (gi > 0) begin : g_b_fwd
            assign b_i[gi][gj] = b_o[gi-1][gj];
         end
         mmu_pe #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
         ) u_pe (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (adv),
            .clr   (clr),
            .a_in  (a_i[gi][gj]),
            .b_in  (b_i[gi][gj]),
            .a_out (a_o[gi][gj]),
            .b_out (b_o[gi][gj]),
            .acc   (acc_w[gi][gj])
         );
      end
   end

endmodule

// File: tb/tb_mmu_array.sv
// Directed self-checking bench for mmu_array at N=2, DATA_W=8.
module tb_mmu_array;

   localparam int unsigned N      = 2;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned ACC_W  = 16;
   localparam int unsigned K_W    = 8;
   localparam int unsigned RW     = N * DATA_W;
   localparam int unsigned IDX_W  = $clog2(N);

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [K_W-1:0]    k_len = '0;
   logic              acc_en = 1'b0;
   logic              sat_en = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [RW-1:0]     in_a = '0;
   logic [RW-1:0]     in_b = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [RW-1:0]     out_row;
   logic [IDX_W-1:0]  out_idx;
   logic              out_last;
   logic              busy;
   logic              done;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [RW-1:0]    a_beats [4];
   logic [RW-1:0]    b_beats [4];
   logic [RW-1:0]    got_rows [N];
   logic [IDX_W-1:0] got_idx [N];
   logic             got_last [N];
   int               got_rcv;
   int               got_done;
   bit               got_stable;

   always #5 clk = ~clk;

   mmu_array #(
      .N      (N),
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .K_W    (K_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .k_len     (k_len),
      .acc_en    (acc_en),
      .sat_en    (sat_en),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_row   (out_row),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   task automatic load_basic();
      a_beats[0] = 16'h0301;  a_beats[1] = 16'h0402;
      b_beats[0] = 16'h0605;  b_beats[1] = 16'h0807;
   endtask

   task automatic start_job(input int k, input bit acc, input bit sat);
      start  = 1'b1;
      k_len  = K_W'(k);
      acc_en = acc;
      sat_en = sat;
      @(negedge clk);
      start  = 1'b0;
   endtask

   task automatic feed_beats(input int k, input logic [7:0] vpat);
      int idx = 0;
      int c   = 0;
      bit acc;
      while (idx < k && c < 64) begin
         in_valid = vpat[c % 8];
         in_a     = a_beats[idx];
         in_b     = b_beats[idx];
         acc      = in_valid && in_ready;
         @(negedge clk);
         if (acc) idx++;
         c++;
      end
      in_valid = 1'b0;
      in_a     = '0;
      in_b     = '0;
      tests_run++;
      if (idx !== k) begin
         tests_failed++;
         $display("FAIL feed_beats: accepted %0d beats, required %0d", idx, k);
      end
   endtask

   task automatic collect(input int stall);
      int            st = 0;
      int            guard = 0;
      logic [RW-1:0] held = '0;
      got_rcv = 0; got_done = 0; got_stable = 1'b1;
      for (int i = 0; i < N; i++) begin
         got_rows[i] = 'x; got_idx[i] = 'x; got_last[i] = 1'bx;
      end
      while (got_rcv < N && guard < 200) begin
         @(negedge clk);
         guard++;
         if (done) got_done++;
         out_ready = 1'b0;
         if (out_valid) begin
            if (st > 0 && out_row !== held) got_stable = 1'b0;
            held = out_row;
            if (st < stall) st++;
            else begin
               got_rows[got_rcv] = out_row;
               got_idx[got_rcv]  = out_idx;
               got_last[got_rcv] = out_last;
               got_rcv++;
               st = 0;
               out_ready = 1'b1;
            end
         end
      end
      @(negedge clk);
      out_ready = 1'b0;
      if (done) got_done++;
      @(negedge clk);
      if (done) got_done++;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      tests_run++;
      if ({in_ready, out_valid, out_row, out_idx, out_last, busy, done} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got rdy=%b vld=%b row=%h idx=%h last=%b busy=%b done=%b, required all 0",
                  in_ready, out_valid, out_row, out_idx, out_last, busy, done);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      load_basic();
      start_job(2, 1'b0, 1'b0);
      tests_run++;
      if (busy !== 1'b1 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL basic_feed_state: got busy=%b in_ready=%b, required 1 1", busy, in_ready);
      end
      feed_beats(2, 8'hFF);
      collect(0);
      tests_run++;
      if (got_rows[0] !== 16'h1613) begin
         tests_failed++; $display("FAIL basic_row0: got %h, required 1613", got_rows[0]);
      end
      tests_run++;
      if (got_rows[1] !== 16'h322B) begin
         tests_failed++; $display("FAIL basic_row1: got %h, required 322b", got_rows[1]);
      end
      tests_run++;
      if ({got_idx[0], got_last[0], got_idx[1], got_last[1]} !== 4'b0011) begin
         tests_failed++;
         $display("FAIL basic_idx_last: got idx0=%0d last0=%b idx1=%0d last1=%b, required 0 0 1 1",
                  got_idx[0], got_last[0], got_idx[1], got_last[1]);
      end
      tests_run++;
      if (got_done !== 1 || busy !== 1'b0) begin
         tests_failed++; $display("FAIL basic_done: got %0d pulses busy=%b, required 1 pulse busy=0", got_done, busy);
      end
   endtask

   task automatic test_accumulate();
      load_basic();
      start_job(2, 1'b1, 1'b0);
      feed_beats(2, 8'hFF);
      collect(0);
      tests_run++;
      if ({got_rows[0], got_rows[1]} !== {16'h2C26, 16'h6456}) begin
         tests_failed++;
         $display("FAIL accumulate_rows: got %h %h, required 2c26 6456", got_rows[0], got_rows[1]);
      end
      start_job(2, 1'b0, 1'b0);
      feed_beats(2, 8'hFF);
      collect(0);
      tests_run++;
      if ({got_rows[0], got_rows[1]} !== {16'h1613, 16'h322B}) begin
         tests_failed++;
         $display("FAIL accumulate_clear_rows: got %h %h, required 1613 322b", got_rows[0], got_rows[1]);
      end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 2; i++) begin
         a_beats[i] = 16'h1010;
         b_beats[i] = 16'h1010;
      end
      start_job(2, 1'b0, 1'b1);
      feed_beats(2, 8'hFF);
      collect(0);
      tests_run++;
      if ({got_rows[0], got_rows[1]} !== {16'hFFFF, 16'hFFFF}) begin
         tests_failed++;
         $display("FAIL saturate_rows: got %h %h, required ffff ffff", got_rows[0], got_rows[1]);
      end
      start_job(2, 1'b0, 1'b0);
      feed_beats(2, 8'hFF);
      collect(0);
      tests_run++;
      if ({got_rows[0], got_rows[1]} !== {16'h0000, 16'h0000}) begin
         tests_failed++;
         $display("FAIL truncate_rows: got %h %h, required 0000 0000", got_rows[0], got_rows[1]);
      end
   endtask

   task automatic test_backpressure();
      load_basic();
      start_job(2, 1'b0, 1'b0);
      feed_beats(2, 8'b0000_1001);
      collect(3);
      tests_run++;
      if ({got_rows[0], got_rows[1]} !== {16'h1613, 16'h322B}) begin
         tests_failed++;
         $display("FAIL backpressure_rows: got %h %h, required 1613 322b", got_rows[0], got_rows[1]);
      end
      tests_run++;
      if (got_stable !== 1'b1 || got_done !== 1) begin
         tests_failed++;
         $display("FAIL backpressure_stable: got stable=%b done=%0d, required stable=1 done=1", got_stable, got_done);
      end
   endtask

   task automatic test_reset_mid_job();
      int dn = 0;
      load_basic();
      start_job(2, 1'b1, 1'b0);
      feed_beats(2, 8'hFF);
      tests_run++;
      if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL midreset_drain_state: got busy=%b rdy=%b vld=%b, required 1 0 0", busy, in_ready, out_valid);
      end
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({in_ready, out_valid, out_row, out_idx, out_last, busy, done} !== '0) begin
         tests_failed++;
         $display("FAIL midreset_outputs: got rdy=%b vld=%b row=%h idx=%h last=%b busy=%b done=%b, required all 0",
                  in_ready, out_valid, out_row, out_idx, out_last, busy, done);
      end
      repeat (3) begin
         @(negedge clk);
         if (done) dn++;
      end
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         if (done) dn++;
      end
      tests_run++;
      if (dn !== 0) begin
         tests_failed++; $display("FAIL midreset_no_done: got %0d pulses, required 0", dn);
      end
      start_job(2, 1'b1, 1'b0);
      feed_beats(2, 8'hFF);
      collect(0);
      tests_run++;
      if ({got_rows[0], got_rows[1]} !== {16'h1613, 16'h322B}) begin
         tests_failed++;
         $display("FAIL midreset_next_job: got %h %h, required 1613 322b", got_rows[0], got_rows[1]);
      end
   endtask

   task automatic test_klen_zero();
      start_job(0, 1'b0, 1'b0);
      start  = 1'b1;
      k_len  = K_W'(2);
      acc_en = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      collect(1);
      tests_run++;
      if ({got_rows[0], got_rows[1]} !== {16'h0000, 16'h0000}) begin
         tests_failed++;
         $display("FAIL klen0_rows: got %h %h, required 0000 0000", got_rows[0], got_rows[1]);
      end
      tests_run++;
      if (got_done !== 1 || got_stable !== 1'b1) begin
         tests_failed++;
         $display("FAIL klen0_done: got done=%0d stable=%b, required 1 1", got_done, got_stable);
      end
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL klen0_start_ignored: got busy=%b vld=%b rdy=%b, required 0 0 0", busy, out_valid, in_ready);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_accumulate();
      test_saturate();
      test_backpressure();
      test_reset_mid_job();
      test_klen_zero();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mmu_array.md
Name: mmu_array

Overview:
- Parametrised N x N output-stationary systolic matrix multiplier. It is the successor to the fixed 2x2 MMU.
- Streams the K dimension through valid/ready beats, skews the inputs internally, drains the array, then returns C one row per beat over a valid/ready output.
- Adds two modes: accumulate-across-jobs and saturating output. Sits between the operand loader and the result writer in the TPU datapath.

Parameters:
- N, 2, array dimension (rows = cols); N >= 2.
- DATA_W, 8, operand and output element width, unsigned.
- ACC_W, 16, accumulator width; must be >= 2*DATA_W.
- K_W, 8, width of k_len.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  job request; sampled only in IDLE
- k_len  in  K_W  number of K beats for the job; latched on start
- acc_en  in  1  1 = keep accumulators from the previous job; latched on start
- sat_en  in  1  1 = saturate output, 0 = truncate; latched on start
- in_valid  in  1  operand beat valid
- in_ready  out  1  operand beat accepted when in_valid & in_ready
- in_a  in  N*DATA_W  column k of A; element i at [i*DATA_W +: DATA_W]
- in_b  in  N*DATA_W  row k of B; element j at [j*DATA_W +: DATA_W]
- out_valid  out  1  result row valid
- out_ready  in  1  result row consumed when out_valid & out_ready
- out_row  out  N*DATA_W  C[r][j] at [j*DATA_W +: DATA_W]
- out_idx  out  $clog2(N)  row index r
- out_last  out  1  high with row N-1
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at job completion

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; all accumulators, skew and PE registers 0.
  - in_ready=0, out_valid=0, out_row=0, out_idx=0, out_last=0, busy=0, done=0.
  - Reset asserted mid-job aborts the job. No done pulse.
- States: IDLE, FEED, DRAIN, OUT.
- IDLE:
  - On start=1, latch k_len, acc_en and sat_en.
  - If acc_en=0, clear all accumulators in that same cycle.
  - Go to FEED, or to OUT if k_len=0. The k_len=0 path performs no MACs and outputs the cleared or retained accumulators.
- FEED:
  - in_ready=1 and the beat counter counts accepted beats.
  - On the cycle the k_len-th beat is accepted, go to DRAIN.
- Array timing:
  - The array advances every cycle in FEED and DRAIN.
  - A cycle with no accepted beat injects zeros, so bubbles add nothing.
  - Row i of in_a is delayed i cycles; column j of in_b is delayed j cycles.
  - PE(i,j) each cycle does acc += a*b, forwards a right and b down.
  - A beat accepted at cycle t contributes to PE(i,j) at cycle t+i+j+1.
- DRAIN: exactly 2N-1 cycles of zero injection, then go to OUT.
- OUT:
  - out_valid=1, with out_idx = row counter starting at 0.
  - Advance the row on each handshake. After the handshake on row N-1, return to IDLE and pulse done=1 the following cycle.
  - out_row holds stable while out_valid & !out_ready.
- Arithmetic:
  - Product is 2*DATA_W bits, zero-extended into ACC_W.
  - Accumulator wraps modulo 2^ACC_W.
  - Output element with sat_en=0: acc[DATA_W-1:0].
  - Output element with sat_en=1: min(acc, 2^DATA_W-1).
- Edge cases:
  - start outside IDLE is ignored.
  - in_valid outside FEED is ignored (in_ready=0).
  - start and done in the same cycle: start is honoured, since done is asserted in IDLE.
- Latency: job time = k_len accepted beats + (2N-1) + N output handshakes.

Decomposition:
- Package mmu_pkg holds:
  - the state enum (IDLE/FEED/DRAIN/OUT);
  - a function sat_trunc(acc, sat_en) parametrised by the widths;
  - localparam DRAIN_CYC = 2N-1.
- One sub-module, mmu_pe: a registers, b registers, accumulator, MAC, and clear input.
- Instantiated N*N times via generate in mmu_array.

Test Plan:
- Basic multiply: N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], k_len=2, acc_en=0, sat_en=0, no stalls -> rows [19,22] then [43,50]; out_last on row 1; done pulses once.
- Accumulate: repeat the basic job with acc_en=1 -> [38,44],[86,100]. Then a job with acc_en=0 and the same data -> [19,22],[43,50].
- Saturate vs truncate: A and B all 16, k_len=2 (acc=512):
  - sat_en=1 -> all 255;
  - sat_en=0 -> all 0.
- Backpressure: in_valid toggled 1,0,0,1 and out_ready low for 3 cycles on each row -> same result as the basic test; out_row stable while stalled.
- Reset mid-job: deassert rst_n during DRAIN -> all outputs 0 immediately, no done. A following job with acc_en=1 yields plain A*B (accumulators were cleared by reset).
- k_len=0 with acc_en=0 -> two all-zero rows, done pulses; start pulsed during OUT is ignored.
